// File: rtl/fir_jmp_sweep_if.sv
// ---------------------------------------------------------------------------
// fir_jmp_sweep_if
// Configuration and output bundle of the jmp sweep controller. The master
// side (system / bench) drives the enable, sample tick and sweep
// configuration. The slave side (the sweep controller) returns the jmp word
// and the direction and turn flags.
// ---------------------------------------------------------------------------
interface fir_jmp_sweep_if #(
  parameter int JMP_WIDTH  = 9,
  parameter int DIV_WIDTH  = 16,
  parameter int HOLD_WIDTH = 8
);

  logic                  en;       // sweep enable
  logic                  vld_i;    // audio sample tick
  logic [JMP_WIDTH-1:0]  jmp_min;  // lower sweep bound (unsigned)
  logic [JMP_WIDTH-1:0]  jmp_max;  // upper sweep bound (unsigned)
  logic [JMP_WIDTH-1:0]  step;     // jmp increment per sweep step
  logic [DIV_WIDTH-1:0]  div;      // step every div+1 ticks
  logic [HOLD_WIDTH-1:0] hold;     // dwell step events at each bound
  logic [JMP_WIDTH-1:0]  jmp;      // phase increment to the FIR stage
  logic                  dir_o;    // 1 while rising or dwelling high
  logic                  turn_o;   // pulse when jmp lands on a bound

  modport master (
    output en, vld_i, jmp_min, jmp_max, step, div, hold,
    input  jmp, dir_o, turn_o
  );

  modport slave (
    input  en, vld_i, jmp_min, jmp_max, step, div, hold,
    output jmp, dir_o, turn_o
  );

endinterface

// File: rtl/fir_jmp_sweep.sv
// ---------------------------------------------------------------------------
// fir_jmp_sweep
// Triangle sweep generator for the jmp (LUT phase-increment) word of the
// modulated FIR stage downstream. jmp ramps from jmp_min to jmp_max and back
// in 'step' increments. One step is taken every div+1 sample ticks. The
// sweep dwells for hold+1 step events at each bound.
//
// Optional build macro: FIR_JMP_SWEEP_SETTLE_EN
//   When defined, every jmp change starts a SETTLE-clock lockout. A step
//   event that falls due during the lockout is deferred. The divider parks at
//   div until the lockout ends, so the filter can finish reloading its
//   coefficient index between jmp changes. When the macro is undefined,
//   SETTLE has no effect.
// ---------------------------------------------------------------------------
module fir_jmp_sweep #(
  parameter int JMP_WIDTH  = 9,
  parameter int DIV_WIDTH  = 16,
  parameter int HOLD_WIDTH = 8,
  parameter int SETTLE     = 4
) (
  input  logic             clk,
  input  logic             rst,
  fir_jmp_sweep_if.slave   io_sweep
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_HOLD_HI,
    S_FALL,
    S_HOLD_LO
  } state_t;

  // Registered state and outputs
  state_t                r_state;
  logic [JMP_WIDTH-1:0]  r_jmp;
  logic                  r_dir;
  logic                  r_turn;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;

  // Next-state values
  state_t                w_state_nxt;
  logic [JMP_WIDTH-1:0]  w_jmp_nxt;
  logic                  w_dir_nxt;
  logic                  w_turn_nxt;
  logic [DIV_WIDTH-1:0]  w_div_cnt_nxt;
  logic [HOLD_WIDTH-1:0] w_hold_cnt_nxt;

  // Step-event qualification and bound arithmetic
  logic                  w_active;     // enabled with a usable range
  logic                  w_tick_due;   // divider has reached its terminal count
  logic                  w_locked;     // settle lockout in progress
  logic                  w_step_ev;    // a sweep step happens this clock
  logic                  w_step_nz;    // step==0 freezes the ramp
  logic [JMP_WIDTH:0]    w_sum;        // rising candidate, carry kept
  logic signed [JMP_WIDTH:0] w_diff;   // falling candidate, may go negative
  logic                  w_hit_max;
  logic                  w_hit_min;

  assign w_active   = io_sweep.en && (io_sweep.jmp_min < io_sweep.jmp_max);
  assign w_tick_due = io_sweep.vld_i && (r_div_cnt == io_sweep.div);
  assign w_step_ev  = w_tick_due && !w_locked;
  assign w_step_nz  = (io_sweep.step != '0);

  // The extra bit keeps an overshoot above jmp_max from wrapping around.
  assign w_sum      = {1'b0, r_jmp} + {1'b0, io_sweep.step};
  assign w_diff     = $signed({1'b0, r_jmp}) - $signed({1'b0, io_sweep.step});
  assign w_hit_max  = (w_sum >= {1'b0, io_sweep.jmp_max});
  assign w_hit_min  = (w_diff <= $signed({1'b0, io_sweep.jmp_min}));

`ifdef FIR_JMP_SWEEP_SETTLE_EN
  localparam int LOCK_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  logic [LOCK_W-1:0] r_lock;

  // Lockout counter: reload on every jmp change, otherwise count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= '0;
    end else if (w_jmp_nxt != r_jmp) begin
      r_lock <= LOCK_W'(SETTLE);
    end else if (r_lock != '0) begin
      r_lock <= r_lock - 1'b1;
    end
  end

  assign w_locked = (r_lock != '0);
`else
  logic w_unused_settle;

  assign w_unused_settle = ^SETTLE;
  assign w_locked        = 1'b0;
`endif

  // State register and registered outputs
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; a blocking assignment here would create
  // order-dependent simulation and a mismatch against synthesis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_jmp      <= '0;
      r_dir      <= 1'b0;
      r_turn     <= 1'b0;
      r_div_cnt  <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_jmp      <= w_jmp_nxt;
      r_dir      <= w_dir_nxt;
      r_turn     <= w_turn_nxt;
      r_div_cnt  <= w_div_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next-state, divider, dwell and jmp update logic
  // NOTE: every output of this block is given a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_jmp_nxt      = r_jmp;
    w_turn_nxt     = 1'b0;
    w_div_cnt_nxt  = r_div_cnt;
    w_hold_cnt_nxt = r_hold_cnt;

    if (!w_active) begin
      // Disabled or degenerate bounds: park on jmp_min with counters cleared.
      w_state_nxt    = S_IDLE;
      w_jmp_nxt      = io_sweep.jmp_min;
      w_div_cnt_nxt  = '0;
      w_hold_cnt_nxt = '0;
    end else if (r_state == S_IDLE) begin
      // Usable range and enabled: start the sweep from the bottom.
      w_state_nxt    = S_RISE;
      w_jmp_nxt      = io_sweep.jmp_min;
      w_div_cnt_nxt  = '0;
      w_hold_cnt_nxt = '0;
    end else begin
      // Sample-tick divider. A due step blocked by the lockout parks at div.
      if (io_sweep.vld_i) begin
        if (w_step_ev) begin
          w_div_cnt_nxt = '0;
        end else if (!w_tick_due) begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end

      if (w_step_ev) begin
        unique case (r_state)
          S_RISE: begin
            if (w_step_nz) begin
              if (w_hit_max) begin
                w_jmp_nxt      = io_sweep.jmp_max;
                w_turn_nxt     = 1'b1;
                w_hold_cnt_nxt = '0;
                w_state_nxt    = S_HOLD_HI;
              end else begin
                w_jmp_nxt = w_sum[JMP_WIDTH-1:0];
              end
            end
          end
          S_HOLD_HI: begin
            if (r_hold_cnt == io_sweep.hold) begin
              w_hold_cnt_nxt = '0;
              w_state_nxt    = S_FALL;
            end else begin
              w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end
          end
          S_FALL: begin
            if (w_step_nz) begin
              if (w_hit_min) begin
                w_jmp_nxt      = io_sweep.jmp_min;
                w_turn_nxt     = 1'b1;
                w_hold_cnt_nxt = '0;
                w_state_nxt    = S_HOLD_LO;
              end else begin
                w_jmp_nxt = w_diff[JMP_WIDTH-1:0];
              end
            end
          end
          S_HOLD_LO: begin
            if (r_hold_cnt == io_sweep.hold) begin
              w_hold_cnt_nxt = '0;
              w_state_nxt    = S_RISE;
            end else begin
              w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end

    // dir_o is registered together with the state it describes.
    w_dir_nxt = (w_state_nxt == S_RISE) || (w_state_nxt == S_HOLD_HI);
  end

  assign io_sweep.jmp    = r_jmp;
  assign io_sweep.dir_o  = r_dir;
  assign io_sweep.turn_o = r_turn;

endmodule

// File: tb/tb_fir_jmp_sweep.sv
// ---------------------------------------------------------------------------
// tb_fir_jmp_sweep
// Scoreboard bench for the jmp sweep controller. The driver applies inputs on
// the falling edge. It advances a behavioural sweep model written in plain
// integer arithmetic and queues the outputs expected after the next rising
// edge. An independent monitor pops the queue and compares after each rising
// edge.
// ---------------------------------------------------------------------------
module tb_fir_jmp_sweep;

  localparam int JMP_WIDTH  = 9;
  localparam int DIV_WIDTH  = 16;
  localparam int HOLD_WIDTH = 8;
  localparam int SETTLE     = 4;

`ifdef FIR_JMP_SWEEP_SETTLE_EN
  localparam int LOCKOUT = SETTLE;
`else
  localparam int LOCKOUT = 0;
`endif

  typedef enum int {M_IDLE, M_RISE, M_HOLD_HI, M_FALL, M_HOLD_LO} mode_t;

  typedef struct {
    int jmp;
    int dir;
    int turn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fir_jmp_sweep_if #(
    .JMP_WIDTH (JMP_WIDTH),
    .DIV_WIDTH (DIV_WIDTH),
    .HOLD_WIDTH(HOLD_WIDTH)
  ) sweep_if ();

  fir_jmp_sweep #(
    .JMP_WIDTH (JMP_WIDTH),
    .DIV_WIDTH (DIV_WIDTH),
    .HOLD_WIDTH(HOLD_WIDTH),
    .SETTLE    (SETTLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_sweep(sweep_if)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  // Behavioural sweep model
  mode_t m_mode  = M_IDLE;
  int    m_jmp   = 0;
  int    m_ticks = 0;   // sample ticks since the last step event
  int    m_dwell = 0;   // step events already spent at the current bound
  int    m_lock  = 0;   // clocks left before another jmp change is allowed

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_jmp   = 0;
    m_ticks = 0;
    m_dwell = 0;
    m_lock  = 0;
  endtask

  // Advance the model by one clock and return the outputs after that clock.
  task automatic model_step(input bit en, input bit vld, input int mn,
                            input int mx, input int st, input int dv,
                            input int hd, output exp_t e);
    int prev;
    int turn;
    prev = m_jmp;
    turn = 0;
    if (!en || mn >= mx) begin
      m_mode = M_IDLE; m_jmp = mn; m_ticks = 0; m_dwell = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RISE; m_jmp = mn; m_ticks = 0; m_dwell = 0;
    end else if (vld) begin
      if (m_ticks != dv) begin
        m_ticks = (m_ticks + 1) % (1 << DIV_WIDTH);
      end else if (m_lock == 0) begin
        m_ticks = 0;
        case (m_mode)
          M_RISE: if (st > 0) begin
            if (m_jmp + st >= mx) begin
              m_jmp = mx; turn = 1; m_dwell = 0; m_mode = M_HOLD_HI;
            end else m_jmp = m_jmp + st;
          end
          M_FALL: if (st > 0) begin
            if (m_jmp - st <= mn) begin
              m_jmp = mn; turn = 1; m_dwell = 0; m_mode = M_HOLD_LO;
            end else m_jmp = m_jmp - st;
          end
          M_HOLD_HI: if (m_dwell == hd) m_mode = M_FALL; else m_dwell++;
          M_HOLD_LO: if (m_dwell == hd) m_mode = M_RISE; else m_dwell++;
          default: ;
        endcase
      end
    end
    if (m_jmp != prev) m_lock = LOCKOUT;
    else if (m_lock > 0) m_lock--;
    e.jmp  = m_jmp;
    e.dir  = (m_mode == M_RISE || m_mode == M_HOLD_HI) ? 1 : 0;
    e.turn = turn;
  endtask

  // Driver: one clock of stimulus with its expected result queued.
  task automatic drive(input bit en, input bit vld, input int mn, input int mx,
                       input int st, input int dv, input int hd);
    exp_t e;
    @(negedge clk);
    rst              = 1'b0;
    sweep_if.en      = en;
    sweep_if.vld_i   = vld;
    sweep_if.jmp_min = mn[JMP_WIDTH-1:0];
    sweep_if.jmp_max = mx[JMP_WIDTH-1:0];
    sweep_if.step    = st[JMP_WIDTH-1:0];
    sweep_if.div     = dv[DIV_WIDTH-1:0];
    sweep_if.hold    = hd[HOLD_WIDTH-1:0];
    model_step(en, vld, mn, mx, st, dv, hd, e);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_jmp"},  int'(sweep_if.jmp),    0);
    check({tag, "_dir"},  int'(sweep_if.dir_o),  0);
    check({tag, "_turn"}, int'(sweep_if.turn_o), 0);
    model_reset();
  endtask

  // Monitor: compare DUT outputs after every rising edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("jmp",    int'(sweep_if.jmp),    e.jmp);
        check("dir_o",  int'(sweep_if.dir_o),  e.dir);
        check("turn_o", int'(sweep_if.turn_o), e.turn);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  mn, mx, st, dv, hd;
    bit  en, vld, found;

    sweep_if.en      = 1'b0;
    sweep_if.vld_i   = 1'b0;
    sweep_if.jmp_min = 9'd10;
    sweep_if.jmp_max = 9'd0;
    sweep_if.step    = 9'd0;
    sweep_if.div     = '0;
    sweep_if.hold    = '0;

    // Reset mid-clock, then idle with jmp_min=10
    #3;
    rst = 1'b1;
    #1;
    check("rst_jmp",  int'(sweep_if.jmp),    0);
    check("rst_turn", int'(sweep_if.turn_o), 0);
    model_reset();
    repeat (3) drive(0, 1, 10, 0, 0, 0, 0);

    // Basic triangle 10..40 step 10, tick every clock
    repeat (24) drive(1, 1, 10, 40, 10, 0, 0);

    // Divider and dwell
    repeat (2)  drive(0, 1, 0, 10, 5, 3, 2);
    repeat (60) drive(1, 1, 0, 10, 5, 3, 2);

    // Overshoot clamp at the top of the range and below zero
    repeat (2)  drive(0, 1, 0, 511, 300, 0, 0);
    repeat (16) drive(1, 1, 0, 511, 300, 0, 0);

    // Degenerate bounds stay idle
    repeat (8) drive(1, 1, 50, 50, 10, 0, 0);

    // step=0 freezes jmp
    repeat (10) drive(1, 1, 20, 90, 0, 0, 0);

    // Shrink jmp_max to 15 while jmp=30 and rising
    drive(0, 1, 10, 40, 10, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      drive(1, 1, 10, 40, 10, 0, 0);
      if (m_jmp == 30 && m_mode == M_RISE) found = 1'b1;
    end
    check("shrink_reached_30", int'(found), 1);
    repeat (8) drive(1, 1, 10, 15, 10, 0, 0);

    // en falling mid-sweep, then async reset mid-sweep
    repeat (5) drive(1, 1, 0, 200, 17, 0, 1);
    drive(0, 1, 0, 200, 17, 0, 1);
    repeat (5) drive(1, 1, 0, 200, 17, 0, 1);
    async_reset("midrst");
    repeat (6) drive(1, 1, 0, 200, 17, 0, 1);

    // Randomised sweep with live configuration changes
    mn = 20; mx = 300; st = 37; dv = 1; hd = 1;
    for (int i = 0; i < 400; i++) begin
      en = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        mn = $urandom_range(0, 200);
        mx = $urandom_range(0, 511);
        dv = $urandom_range(0, 3);
        hd = $urandom_range(0, 3);
        en = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        mx = $urandom_range(0, 511);
      end
      if ($urandom_range(0, 24) == 0) st = $urandom_range(0, 140);
      if ($urandom_range(0, 59) == 0) en = 1'b0;
      vld = ($urandom_range(0, 3) != 0);
      if (i == 200) async_reset("rndrst");
      drive(en, vld, mn, mx, st, dv, hd);
    end

    // Let the scoreboard drain
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
